// File: rtl/q2a03_pkg.sv
// Shared Q2A03 bus definitions: DMA state encoding, register addresses and
// the CPU read/write direction encoding.
package q2a03_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/q2a03_bus_mux.sv
// Combinational CPU/DMA select onto the system bus. The DMA side wins
// whenever dma_sel is high; otherwise the CPU core passes straight through.
module q2a03_bus_mux (
  input  logic        dma_sel,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wr_data,
  input  logic        dma_rdwr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  output logic        bus_rdwr
);

  assign bus_addr    = dma_sel ? dma_addr    : cpu_addr;
  assign bus_wr_data = dma_sel ? dma_wr_data : cpu_wr_data;
  assign bus_rdwr    = dma_sel ? dma_rdwr    : cpu_rdwr;

endmodule

// File: rtl/q2a03_oam_dma.sv
// Sprite DMA controller: halts the CPU, then copies one page of memory to the
// sprite data port on alternating get/put cycles before releasing the bus.
module q2a03_oam_dma
  import q2a03_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_ADDR,
  parameter logic [15:0] TARGET_ADDR  = OAMDATA_ADDR,
  parameter int unsigned LENGTH       = 256
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        cycle_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  input  logic [7:0]  bus_rd_data,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  output logic        bus_rdwr,
  output logic        cpu_ready,
  output logic        dma_active
);

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

  dma_state_t  state;
  dma_state_t  state_n;
  logic        phase;
  logic [7:0]  page;
  logic [7:0]  index;
  logic [7:0]  buffer;
  logic        ready_q;
  logic        trigger;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wr_data;
  logic        dma_rdwr;

  assign trigger = (cpu_rdwr == RW_WRITE) && (cpu_addr == TRIGGER_ADDR);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (trigger) state_n = HALT;
      // phase=1 now means the following cycle is a get cycle
      HALT:  if (cpu_rdwr == RW_READ) state_n = phase ? READ : ALIGN;
      ALIGN: state_n = READ;
      READ:  state_n = WRITE;
      WRITE: state_n = (index == LAST_INDEX) ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge G_clock) begin
    if (G_reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      page    <= '0;
      index   <= '0;
      buffer  <= '0;
      ready_q <= 1'b1;
    end else if (cycle_en) begin
      state   <= state_n;
      phase   <= ~phase;
      ready_q <= (state_n == IDLE);
      if (state == IDLE && trigger) begin
        page  <= cpu_wr_data;
        index <= '0;
      end
      if (state == READ) buffer <= bus_rd_data;
      if (state == WRITE && index != LAST_INDEX) index <= index + 8'd1;
    end
  end

  always_comb begin
    dma_addr    = cpu_addr;
    dma_wr_data = buffer;
    dma_rdwr    = RW_READ;
    unique case (state)
      READ:  dma_addr = {page, index};
      WRITE: begin
        dma_addr = TARGET_ADDR;
        dma_rdwr = RW_WRITE;
      end
      default: ;
    endcase
  end

  assign dma_active = (state == ALIGN) || (state == READ) || (state == WRITE);
  assign cpu_ready  = ready_q;

  q2a03_bus_mux u_bus_mux (
    .dma_sel     (dma_active),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rdwr    (cpu_rdwr),
    .dma_addr    (dma_addr),
    .dma_wr_data (dma_wr_data),
    .dma_rdwr    (dma_rdwr),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rdwr    (bus_rdwr)
  );

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Scoreboard bench for q2a03_oam_dma: a full-length instance and a LENGTH=1
// instance share the CPU stimulus; a monitor checks every bus cycle.
module tb_q2a03_oam_dma;

  logic        G_clock = 1'b0;
  logic        G_reset;
  logic        cycle_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rdwr;

  logic [7:0]  bus_rd_data, bus_rd_data1;
  logic [15:0] bus_addr, bus_addr1;
  logic [7:0]  bus_wr_data, bus_wr_data1;
  logic        bus_rdwr, bus_rdwr1;
  logic        cpu_ready, cpu_ready1;
  logic        dma_active, dma_active1;

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  data;
  } xact_t;

  xact_t       q0[$];
  xact_t       q1[$];
  logic [7:0]  mem [0:65535];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int halted = 0;
  int halted1 = 0;
  int writes_done = 0;
  int zero_hits = 0;
  bit gap = 0;

  always #5 G_clock = ~G_clock;

  assign bus_rd_data  = mem[bus_addr];
  assign bus_rd_data1 = mem[bus_addr1];

  q2a03_oam_dma u_dut (
    .G_clock(G_clock), .G_reset(G_reset), .cycle_en(cycle_en),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rdwr(cpu_rdwr),
    .bus_rd_data(bus_rd_data), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rdwr(bus_rdwr), .cpu_ready(cpu_ready), .dma_active(dma_active)
  );

  q2a03_oam_dma #(.LENGTH(1)) u_dut1 (
    .G_clock(G_clock), .G_reset(G_reset), .cycle_en(cycle_en),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rdwr(cpu_rdwr),
    .bus_rd_data(bus_rd_data1), .bus_addr(bus_addr1), .bus_wr_data(bus_wr_data1),
    .bus_rdwr(bus_rdwr1), .cpu_ready(cpu_ready1), .dma_active(dma_active1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every closing cycle_en either pops a DMA transaction or checks passthrough.
  always @(negedge G_clock) begin
    xact_t e;
    if (!G_reset && cycle_en) begin
      if (!cpu_ready)  halted++;
      if (!cpu_ready1) halted1++;
      if (dma_active) begin
        if (bus_addr == 16'h0000) zero_hits++;
        if (q0.size() == 0) check("dma_unexpected", 32'(bus_addr), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          check("dma_addr", 32'(bus_addr), 32'(e.addr));
          check("dma_rdwr", 32'(bus_rdwr), 32'(e.rdwr));
          if (e.rdwr == 1'b0) begin
            check("dma_wdata", 32'(bus_wr_data), 32'(e.data));
            writes_done++;
          end
        end
      end else begin
        check("pass", {bus_rdwr, bus_wr_data, bus_addr}, {cpu_rdwr, cpu_wr_data, cpu_addr});
      end
      if (dma_active1) begin
        if (q1.size() == 0) check("dma1_unexpected", 32'(bus_addr1), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          check("dma1_addr", 32'(bus_addr1), 32'(e.addr));
          check("dma1_rdwr", 32'(bus_rdwr1), 32'(e.rdwr));
          if (e.rdwr == 1'b0) check("dma1_wdata", 32'(bus_wr_data1), 32'(e.data));
        end
      end else begin
        check("pass1", {bus_rdwr1, bus_wr_data1, bus_addr1}, {cpu_rdwr, cpu_wr_data, cpu_addr});
      end
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
    cpu_addr = a; cpu_rdwr = rw; cpu_wr_data = d;
    if (gap) begin
      cycle_en = 1'b0;
      @(posedge G_clock); #1;
    end
    cycle_en = 1'b1;
    @(posedge G_clock); #1;
    cyc++;
  endtask

  // Trigger on a get (put_cyc=0) or put (put_cyc=1) cycle, followed by nw CPU writes.
  task automatic run_xfer(input logic [7:0] pg, input int nw, input bit put_cyc, input bit abort);
    bit al;
    int guard;
    while ((cyc % 2) != int'(put_cyc)) cpu_cycle(16'h8000, 1'b1, 8'h00);
    al = ((cyc + 1 + nw) % 2) == 0;
    halted = 0; halted1 = 0; writes_done = 0;
    if (al) begin
      q0.push_back('{addr: 16'h8000, rdwr: 1'b1, data: 8'h00});
      q1.push_back('{addr: 16'h8000, rdwr: 1'b1, data: 8'h00});
    end
    for (int i = 0; i < 256; i++) begin
      q0.push_back('{addr: {pg, 8'(i)}, rdwr: 1'b1, data: 8'h00});
      q0.push_back('{addr: 16'h2004, rdwr: 1'b0, data: mem[{pg, 8'(i)}]});
    end
    q1.push_back('{addr: {pg, 8'h00}, rdwr: 1'b1, data: 8'h00});
    q1.push_back('{addr: 16'h2004, rdwr: 1'b0, data: mem[{pg, 8'h00}]});

    cpu_cycle(16'h4014, 1'b0, pg);
    check("ready_fall", 32'(cpu_ready), 32'd0);
    for (int k = 0; k < nw; k++) begin
      // second push write hits the trigger address and must be ignored
      cpu_cycle((k == 1) ? 16'h4014 : 16'h01FD, 1'b0, 8'h66);
      check("halt_ready", 32'(cpu_ready), 32'd0);
      check("halt_active", 32'(dma_active), 32'd0);
    end

    guard = 0;
    while (cpu_ready == 1'b0 && guard < 3000) begin
      if (abort && dma_active && bus_rdwr == 1'b0 && writes_done == 99) begin
        G_reset = 1'b1;
        cpu_addr = 16'h8000; cpu_rdwr = 1'b1; cpu_wr_data = 8'h00; cycle_en = 1'b1;
        @(posedge G_clock); #1;
        G_reset = 1'b0;
        cyc = 0;
        check("abort_ready", 32'(cpu_ready), 32'd1);
        check("abort_active", 32'(dma_active), 32'd0);
        check("abort_bus", {bus_rdwr, bus_addr}, {cpu_rdwr, cpu_addr});
        q0.delete(); q1.delete();
        return;
      end
      cpu_cycle(16'h8000, 1'b1, 8'h00);
      guard++;
    end
    if (guard >= 3000) check("timeout", 32'(guard), 32'd0);
    check("halted", 32'(halted), 32'(1 + nw + int'(al) + 512));
    check("halted1", 32'(halted1), 32'(1 + nw + int'(al) + 2));
    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++)
      mem[a] = (a[15:8] == 8'hFF) ? (8'hA5 ^ 8'(a)) : (8'(a) + 8'(a >> 8) + 8'h3C);

    G_reset = 1'b1; cycle_en = 1'b0;
    cpu_addr = 16'h8000; cpu_rdwr = 1'b1; cpu_wr_data = 8'h00;
    repeat (2) @(posedge G_clock);
    #1;
    G_reset = 1'b0;
    cyc = 0;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_bus", {bus_rdwr, bus_wr_data, bus_addr}, {cpu_rdwr, cpu_wr_data, cpu_addr});
    check("rst_ready1", 32'(cpu_ready1), 32'd1);
    check("rst_active1", 32'(dma_active1), 32'd0);

    run_xfer(8'h02, 0, 1'b0, 1'b0);
    run_xfer(8'h02, 0, 1'b1, 1'b0);
    run_xfer(8'h05, 2, 1'b0, 1'b0);

    gap = 1'b1;
    zero_hits = 0;
    run_xfer(8'hFF, 0, 1'b0, 1'b0);
    check("zero_access", 32'(zero_hits), 32'd0);
    gap = 1'b0;

    run_xfer(8'h07, 0, 1'b0, 1'b1);
    run_xfer(8'h03, 0, 1'b1, 1'b0);
    run_xfer(8'h03, 0, 1'b0, 1'b0);

    repeat (3) cpu_cycle(16'h8000, 1'b1, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
